// File: rtl/sr_ff_arbiter.sv
// Round-robin arbiter that serialises set/reset/hold commands from NREQ agents
// onto one shared bank of NBITS SR flops, rejecting S=R=1 and out-of-range indices.
module sr_ff_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_cmd,
  input  logic [IDXW*NREQ-1:0] req_idx,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     qbar,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, APPLY} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, pick;
  logic            found;
  logic [1:0]      cmd_q, cmd_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d, err_q, err_d;
  logic [NBITS-1:0] bank_q, bank_d;
  logic            idx_ok;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int j;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = (int'(ptr_q) + off) % NREQ;
      if (req[j]) begin
        pick  = PW'(j);
        found = 1'b1;
      end
    end
  end

  assign idx_ok = int'(idx_q) < NBITS;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    gnt_d   = '0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    bank_d  = bank_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d       = pick;
          cmd_d       = req_cmd[2*int'(pick) +: 2];
          idx_d       = req_idx[IDXW*int'(pick) +: IDXW];
          gnt_d[pick] = 1'b1;
          busy_d      = 1'b1;
          state_d     = APPLY;
        end
      end
      APPLY: begin
        state_d = IDLE;
        ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
        // cmd[1] is the value written: 10 sets, 01 resets.
        if (cmd_q != 2'b00) begin
          if (cmd_q == 2'b11 || !idx_ok) err_d = 1'b1;
          else                           bank_d[idx_q] = cmd_q[1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      cmd_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      bank_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      bank_q  <= bank_d;
    end
  end

  assign gnt  = gnt_q;
  assign q    = bank_q;
  assign qbar = ~bank_q;
  assign busy = busy_q;
  assign err  = err_q;

endmodule

// File: doc/sr_ff_arbiter.md
Name: sr_ff_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bank of NBITS SR flip-flops among NREQ requesters.
- Each requester posts a set, reset or hold command for one flop index.
- The block grants one requester at a time and applies that command to the bank.
- It blocks the illegal S=R=1 condition and out-of-range indices, flagging both as errors.
- It sits between the control agents and the SR flip-flop state bank, and is the only writer of that bank.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NBITS, 8, number of SR flip-flops in the bank.
- IDXW, 3, width of each flop index field; 2^IDXW >= NBITS.

Ports:
- clk  in  1  rising-edge clock.
- clear  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request. Held high until the requester samples its gnt bit.
- req_cmd  in  2*NREQ  per-requester command; requester i uses bits [2i+1:2i]. 00 hold, 01 reset, 10 set, 11 illegal.
- req_idx  in  IDXW*NREQ  per-requester target flop index; requester i uses bits [IDXW*i+IDXW-1:IDXW*i].
- gnt  out  NREQ  one-hot grant, high for exactly one cycle per serviced command.
- q  out  NBITS  flop bank true outputs.
- qbar  out  NBITS  flop bank complement outputs; always equal to ~q.
- busy  out  1  high while a granted command is being applied (state APPLY).
- err  out  1  one-cycle pulse when an applied command is illegal (cmd 11) or has idx >= NBITS.

Behaviour:
- Reset is synchronous and active-high on clear. The clock is one domain, clk.
- Clear values: q=0, qbar=all ones, gnt=0, busy=0, err=0, state=IDLE, round-robin pointer ptr=0.
- Clear dominates every other event. Clear asserted while in APPLY aborts the command: no bank update and no err pulse.
- FSM has two states, IDLE and APPLY.
- IDLE, on an edge where req != 0:
  - Winner w = first index with req set, searching from ptr upward and wrapping modulo NREQ.
  - Latch w, req_cmd[w] and req_idx[w].
  - gnt <= onehot(w), busy <= 1, state <= APPLY.
- IDLE, on an edge where req == 0: hold all registers; gnt, busy and err are 0.
- APPLY, on the next edge:
  - gnt <= 0, busy <= 0, state <= IDLE, ptr <= (w+1) mod NREQ.
  - cmd 10 with idx < NBITS: q[idx] <= 1.
  - cmd 01 with idx < NBITS: q[idx] <= 0.
  - cmd 00: no change and no error.
  - cmd 11, or idx >= NBITS (any cmd other than 00): no change; err <= 1 for one cycle.
  - Flops other than idx are never disturbed.
- Latency: a request sampled at edge k gives gnt high after edge k; the bank update is visible after edge k+1.
- Throughput: at most one command per 2 cycles. A new arbitration can start at edge k+2.
- Handshake: a requester that sees its gnt bit high drops req, or presents its next command, before edge k+2. If req is still high at edge k+2, it is treated as a new request.
- Command fields are sampled only at the IDLE grant edge. Changes while in APPLY have no effect on the command being applied.
- Fairness: ptr advances past the last winner, so with all NREQ requesting continuously each requester is served once every 2*NREQ cycles.
- The pointer wraps from NREQ-1 to 0.
- Requests arriving during APPLY are ignored until the next IDLE edge. They are not lost as long as req is held.

Test Plan:
- Clear high for 2 edges, then low -> q=8'h00, qbar=8'hFF, gnt=0, busy=0, err=0.
- req=4'b0001, cmd0=10, idx0=3 -> gnt=0001 for one cycle, busy=1 in the same cycle; q=8'h08 one edge later; err stays 0.
- All four requesters request continuously; set commands to idx 0,1,2,3 from req 0..3 -> gnt sequence 0001,0010,0100,1000, each 2 cycles apart; q=8'h0F afterwards. Then req0 asks to reset idx 0 -> q=8'h0E.
- req2 with cmd 11, idx 5, and then req2 with cmd 10, idx 7 when NBITS=6 -> each gives a gnt pulse, an err pulse one edge later, and q unchanged.
- Same-index conflict: req1 sets idx 4 and req3 resets idx 4, both asserted at once with ptr=0 -> req1 served first (q[4]=1), then req3 (q[4]=0); final q[4]=0 and qbar[4]=1.
- Clear asserted on the APPLY edge of a set to idx 2 -> q[2] stays 0, state returns to IDLE, ptr=0, no err pulse.
